// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Brief    : CPU request/response and data-memory bus of the 16-bit LSU
//  Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write_en;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  mem_read_data,
        output req_ready, resp_valid, resp_data, resp_err,
        output mem_read, mem_write_en, mem_access_addr, mem_write_data
    );

    modport memory (
        input  mem_read, mem_write_en, mem_access_addr, mem_write_data,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Brief    : byte/halfword load-store unit for a 16-bit word-addressed memory
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit (
    input  wire logic        clock,
    input  wire logic        reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RMW_READ = 3'd2,
        S_WRITE    = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_size;
    logic        r_signed;
    logic [15:0] r_resp_data;
    logic        r_resp_err;

    logic [7:0]  w_sel_byte;
    logic [15:0] w_load_result;
    logic [15:0] w_merged;

    // Little-endian lane: odd byte address lives in the upper half of the word
    assign w_sel_byte    = r_addr[0] ? bus.mem_read_data[15:8] : bus.mem_read_data[7:0];
    assign w_load_result = r_size   ? bus.mem_read_data :
                           r_signed ? {{8{w_sel_byte[7]}}, w_sel_byte} :
                                      {8'h00, w_sel_byte};
    assign w_merged      = r_addr[0] ? {r_wdata[7:0], bus.mem_read_data[7:0]} :
                                       {bus.mem_read_data[15:8], r_wdata[7:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_size && bus.req_addr[0]) begin
                        w_state_next = S_RESP;
                    end else if (!bus.req_write) begin
                        w_state_next = S_LOAD;
                    end else if (bus.req_size) begin
                        w_state_next = S_WRITE;
                    end else begin
                        w_state_next = S_RMW_READ;
                    end
                end
            end
            S_LOAD:     w_state_next = S_RESP;
            S_RMW_READ: w_state_next = S_WRITE;
            S_WRITE:    w_state_next = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_size      <= 1'b0;
            r_signed    <= 1'b0;
            r_resp_data <= 16'h0000;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_size      <= bus.req_size;
                        r_signed    <= bus.req_signed;
                        r_resp_data <= 16'h0000;
                        r_resp_err  <= bus.req_size & bus.req_addr[0];
                    end
                end
                S_LOAD:     r_resp_data <= w_load_result;
                // The merged word replaces the store data so WRITE needs no size mux
                S_RMW_READ: r_wdata     <= w_merged;
                default: ;
            endcase
        end
    end

    // Memory strobes decode from state alone so an async reset kills them at once
    always_comb begin
        bus.req_ready       = (r_state == S_IDLE) && !reset;
        bus.resp_valid      = 1'b0;
        bus.resp_data       = 16'h0000;
        bus.resp_err        = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_write_en    = 1'b0;
        bus.mem_access_addr = 16'h0000;
        bus.mem_write_data  = 16'h0000;
        case (r_state)
            S_LOAD, S_RMW_READ: begin
                bus.mem_read        = 1'b1;
                bus.mem_access_addr = r_addr;
            end
            S_WRITE: begin
                bus.mem_write_en    = 1'b1;
                bus.mem_access_addr = r_addr;
                bus.mem_write_data  = r_wdata;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = r_resp_data;
                bus.resp_err   = r_resp_err;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Brief    : scoreboard bench for load_store_unit against a word-array model
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b1;
    bit   hold_low = 1'b0;
    bit   fast = 1'b0;
    int   cyc = 0;
    int   writes = 0;
    int   reads = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    always #5 clock = ~clock;

    load_store_unit_if bus();

    load_store_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [15:0] init_word(int i);
        if (i == 32'h10) return 16'h80F1;
        if (i == 32'h20) return 16'h1234;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_access_addr[15:1]] : 16'h0000;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.mem_write_en) writes <= writes + 1;
        if (bus.mem_read)     reads  <= reads + 1;
        if (preload) begin
            for (int i = 0; i < 32768; i++) mem[i] <= init_word(i);
        end else if (bus.mem_write_en) begin
            mem[bus.mem_access_addr[15:1]] <= bus.mem_write_data;
        end
    end

    task automatic check(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    task automatic fail(string n);
        checks++;
        errors++;
        $display("FAIL %s bound expired", n);
    endtask

    // Reference: one request in, expected response out, memory updated
    function automatic exp_t model(bit w, bit sz, bit sg, logic [15:0] a, logic [15:0] d);
        exp_t        e;
        logic [15:0] word;
        logic [7:0]  b;
        int          sh;
        word   = ref_mem[a >> 1];
        sh     = a[0] ? 8 : 0;
        b      = 8'((word >> sh) & 16'h00FF);
        e.data = 16'h0000;
        e.err  = 1'b0;
        e.acc  = 0;
        if (sz && a[0]) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!w) begin
            e.lat = 2;
            if (sz)      e.data = word;
            else if (sg) e.data = 16'($signed(b));
            else         e.data = {8'h00, b};
        end else if (sz) begin
            e.lat = 2;
            ref_mem[a >> 1] = d;
        end else begin
            e.lat = 3;
            ref_mem[a >> 1] = (word & ~(16'h00FF << sh)) | (16'(d[7:0]) << sh);
        end
        return e;
    endfunction

    task automatic issue(bit w, bit sz, bit sg, logic [15:0] a, logic [15:0] d);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        while (!bus.req_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!bus.req_ready) begin
            fail("accept_timeout");
        end else begin
            e     = model(w, sz, sg, a, d);
            e.acc = cyc;
            q.push_back(e);
        end
        @(negedge clock);
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom);
        bus.req_size   = 1'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = 16'($urandom);
        bus.req_wdata  = 16'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || bus.resp_valid) && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (q.size() != 0 || bus.resp_valid) fail("drain_timeout");
    endtask

    task automatic monitor();
        bit          in_resp;
        logic [15:0] hd;
        logic        he;
        exp_t        e;
        in_resp = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_resp = 1'b0;
            end else if (bus.resp_valid) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        fail("unexpected_resp");
                    end else begin
                        e = q.pop_front();
                        check("resp_data", 32'(bus.resp_data), 32'(e.data));
                        check("resp_err", 32'(bus.resp_err), 32'(e.err));
                        check("latency", cyc - e.acc, e.lat);
                    end
                    hd = bus.resp_data;
                    he = bus.resp_err;
                    in_resp = 1'b1;
                end else begin
                    check("resp_stable", {15'h0, bus.resp_err, bus.resp_data}, {15'h0, he, hd});
                end
                check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
                check("mem_idle_in_resp",
                      {bus.mem_read, bus.mem_write_en, bus.mem_access_addr[7:0], bus.mem_write_data[7:0]} |
                      {18'h0, bus.mem_access_addr[15:8], bus.mem_write_data[15:8]}, 32'd0);
                if (bus.resp_ready) in_resp = 1'b0;
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clock);
            #1;
            if (hold_low)  bus.resp_ready = 1'b0;
            else if (fast) bus.resp_ready = 1'b1;
            else           bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Reset while a byte store sits in WRITE (use_write=1) or RMW_READ (use_write=0)
    task automatic reset_during(bit use_write, logic [15:0] a);
        logic [15:0] saved;
        int          w0;
        int          t;
        saved = ref_mem[a >> 1];
        w0    = writes;
        t     = 0;
        issue(1'b1, 1'b0, 1'b0, a, 16'h0055);
        while (!(use_write ? bus.mem_write_en : bus.mem_read) && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!(use_write ? bus.mem_write_en : bus.mem_read)) fail("reach_state_timeout");
        reset = 1'b1;
        #1;
        check("rst_outputs",
              {bus.mem_read, bus.mem_write_en, bus.resp_valid, bus.resp_err, bus.resp_data[11:0]} |
              {16'h0, bus.mem_access_addr} | {16'h0, bus.mem_write_data} | {16'h0, bus.resp_data},
              32'd0);
        ref_mem[a >> 1] = saved;
        q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        check("rst_mem_unchanged", 32'(mem[a >> 1]), 32'(saved));
        check("rst_no_write", writes - w0, 0);
    endtask

    initial begin
        int          r0;
        int          w0;
        int          t;
        int          bad;
        logic [15:0] a;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0000;
        bus.req_wdata  = 16'h0000;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
        fork
            monitor();
            ready_driver();
            begin
                #2000000;
                $display("FAIL watchdog bound expired");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clock);
        check("reset_outputs",
              {bus.mem_read, bus.mem_write_en, bus.resp_valid, bus.resp_err} |
              {16'h0, bus.resp_data} | {16'h0, bus.mem_access_addr} | {16'h0, bus.mem_write_data},
              32'd0);
        preload = 1'b0;
        reset   = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // Signed and unsigned byte loads from word 0x0010
        fast = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000);
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
        drain();

        // Byte store into the upper lane of word 0x0020
        w0 = writes;
        issue(1'b1, 1'b0, 1'b0, 16'h0041, 16'h00AB);
        drain();
        check("byte_store_word", 32'(mem[16'h0020]), 32'h0000AB34);
        check("byte_store_pulses", writes - w0, 1);

        // Misaligned halfword load never touches memory
        r0 = reads;
        w0 = writes;
        issue(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        drain();
        check("misaligned_no_mem", (reads - r0) + (writes - w0), 0);

        // Response held with resp_ready low
        hold_low = 1'b1;
        w0 = writes;
        issue(1'b1, 1'b1, 1'b0, 16'h0100, 16'hBEEF);
        t = 0;
        while (!bus.resp_valid && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!bus.resp_valid) fail("hold_resp_timeout");
        for (int i = 0; i < 5; i++) begin
            check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clock);
        end
        hold_low = 1'b0;
        drain();
        check("hold_store_word", 32'(mem[16'h0080]), 32'h0000BEEF);
        check("hold_store_pulses", writes - w0, 1);

        // Random traffic over a small window plus the top of memory
        for (int n = 0; n < 300; n++) begin
            fast = (n >= 150);
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF - 16'($urandom_range(0, 1));
            else                           a = 16'($urandom_range(0, 63));
            issue(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
        end
        drain();

        reset_during(1'b1, 16'h0031);
        reset_during(1'b0, 16'h0030);

        bad = 0;
        for (int i = 0; i < 40; i++) if (mem[i] !== ref_mem[i]) bad++;
        if (mem[16'h0080] !== ref_mem[16'h0080]) bad++;
        if (mem[16'h7FFF] !== ref_mem[16'h7FFF]) bad++;
        check("final_memory_words_differing", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
